healthcare_sensor_frame_rx: RTL

HEALTHCARE_SENSOR_FRAME_RX -- requirements
Module: healthcare_sensor_frame_rx

---
 rtl/healthcare_sensor_frame_rx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/healthcare_sensor_frame_rx.sv
// Serial receiver for healthcare sensor frames.
//
// A frame is an 8-bit sync pattern, a 50-bit payload and one even-parity bit,
// all sent MSB-first, one bit per s_valid beat. The receiver hunts for the sync
// pattern with a sliding window. It then collects the payload and checks parity.
// Good frames are published to the field outputs, which hold until the next good
// frame. The receiver aborts a frame when the gap between beats grows too long.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   s_valid, s_bit    serial input; s_bit is sampled when s_valid is high
//   pressureData .. tempSensorValue
//                     fields of the last good frame
//   frame_valid       one-cycle pulse when a good frame is published
//   parity_error      one-cycle pulse when a frame is dropped on bad parity
//   timeout_error     one-cycle pulse when a frame is aborted on an idle gap
//   busy              high while receiving payload or waiting for parity
module healthcare_sensor_frame_rx #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic       s_bit,
    output logic [5:0] pressureData,
    output logic [3:0] bloodPH,
    output logic [2:0] bloodType,
    output logic [7:0] fdSensorValue,
    output logic [7:0] fdFactoryValue,
    output logic [7:0] bloodSensor,
    output logic [4:0] factotyBaseTemp,
    output logic [3:0] factotyTempCoef,
    output logic [3:0] tempSensorValue,
    output logic       frame_valid,
    output logic       parity_error,
    output logic       timeout_error,
    output logic       busy
);

    localparam int unsigned GapWidth = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [GapWidth-1:0] GapLimit = GapWidth'(TIMEOUT);
    localparam logic [5:0] LastBeat = 6'd49;

    typedef enum logic [1:0] {
        StHunt,
        StPayload,
        StParity
    } rxState_t;

    rxState_t            state;
    // Last seven hunted bits. Together with the incoming bit they form the
    // 8-bit sync window. The oldest bit would never be compared, so it is not kept.
    logic [6:0]          huntReg;
    logic [49:0]         shiftReg;
    logic [5:0]          beatCnt;
    logic [GapWidth-1:0] gapCnt;
    logic [7:0]          huntWindow;

    assign huntWindow = {huntReg, s_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= StHunt;
            huntReg         <= '0;
            shiftReg        <= '0;
            beatCnt         <= '0;
            gapCnt          <= '0;
            pressureData    <= '0;
            bloodPH         <= '0;
            bloodType       <= '0;
            fdSensorValue   <= '0;
            fdFactoryValue  <= '0;
            bloodSensor     <= '0;
            factotyBaseTemp <= '0;
            factotyTempCoef <= '0;
            tempSensorValue <= '0;
            frame_valid     <= 1'b0;
            parity_error    <= 1'b0;
            timeout_error   <= 1'b0;
            busy            <= 1'b0;
        end else begin
            frame_valid   <= 1'b0;
            parity_error  <= 1'b0;
            timeout_error <= 1'b0;
            case (state)
                StHunt: begin
                    gapCnt <= '0;
                    if (s_valid) begin
                        huntReg <= huntWindow[6:0];
                        if (huntWindow == SYNC) begin
                            state   <= StPayload;
                            busy    <= 1'b1;
                            beatCnt <= '0;
                        end
                    end
                end
                StPayload, StParity: begin
                    if (gapCnt == GapLimit) begin
                        // The abort takes priority over a beat on the same edge.
                        timeout_error <= 1'b1;
                        state         <= StHunt;
                        busy          <= 1'b0;
                        huntReg       <= '0;
                        beatCnt       <= '0;
                        gapCnt        <= '0;
                    end else if (!s_valid) begin
                        gapCnt <= gapCnt + GapWidth'(1);
                    end else if (state == StPayload) begin
                        gapCnt   <= '0;
                        shiftReg <= {shiftReg[48:0], s_bit};
                        if (beatCnt == LastBeat) begin
                            state   <= StParity;
                            beatCnt <= '0;
                        end else begin
                            beatCnt <= beatCnt + 6'd1;
                        end
                    end else begin
                        if (((^shiftReg) ^ s_bit) == 1'b0) begin
                            pressureData    <= shiftReg[49:44];
                            bloodPH         <= shiftReg[43:40];
                            bloodType       <= shiftReg[39:37];
                            fdSensorValue   <= shiftReg[36:29];
                            fdFactoryValue  <= shiftReg[28:21];
                            bloodSensor     <= shiftReg[20:13];
                            factotyBaseTemp <= shiftReg[12:8];
                            factotyTempCoef <= shiftReg[7:4];
                            tempSensorValue <= shiftReg[3:0];
                            frame_valid     <= 1'b1;
                        end else begin
                            parity_error <= 1'b1;
                        end
                        state   <= StHunt;
                        busy    <= 1'b0;
                        huntReg <= '0;
                        beatCnt <= '0;
                        gapCnt  <= '0;
                    end
                end
                default: begin
                    state   <= StHunt;
                    busy    <= 1'b0;
                    huntReg <= '0;
                    beatCnt <= '0;
                    gapCnt  <= '0;
                end
            endcase
        end
    end

endmodule
